// File: rtl/axis_fifo_pkt.sv
// Single-clock AXI-Stream FIFO with TLAST transport, occupancy flags and an
// optional store-and-forward packet mode that falls back to cut-through for oversize packets.
module axis_fifo_pkt #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int PACKET_MODE  = 0,
    parameter int ALMOST_FULL  = 12,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      fifo_empty,
    output logic                      fifo_full,
    output logic                      fifo_almost_full,
    output logic                      fifo_almost_empty,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(ALMOST_FULL);
    localparam logic [PW-1:0] AE_C    = PW'(ALMOST_EMPTY);
    localparam logic [PW-1:0] ZERO_C  = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_C   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_STORE = 1'b0,
        ST_CUT   = 1'b1
    } state_t;

    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [DATA_WIDTH:0] head_s;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    state_t        state_q, state_d;
    logic          s_tready_q, s_tready_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;

    logic          m_tvalid_s;
    logic          wr_acc_s, rd_acc_s;
    logic          wr_last_s, rd_last_s;

    assign head_s            = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_tdata      = head_s[DATA_WIDTH-1:0];
    assign m_axis_tlast      = head_s[DATA_WIDTH];
    assign m_axis_tvalid     = m_tvalid_s;
    assign s_axis_tready     = s_tready_q;
    assign fifo_empty        = empty_q;
    assign fifo_full         = full_q;
    assign fifo_almost_full  = afull_q;
    assign fifo_almost_empty = aempty_q;
    assign fifo_count        = count_q;

    assign wr_acc_s  = s_axis_tvalid & s_tready_q;
    assign rd_acc_s  = m_tvalid_s & m_axis_tready;
    assign wr_last_s = wr_acc_s & s_axis_tlast;
    assign rd_last_s = rd_acc_s & m_axis_tlast;

    // Output valid: in packet mode the head is only offered once its packet is complete,
    // or while an oversize packet is being cut through.
    always_comb begin
        m_tvalid_s = 1'b0;
        if (PACKET_MODE == 0) begin
            m_tvalid_s = (count_q != ZERO_C);
        end else if (state_q == ST_CUT) begin
            m_tvalid_s = (count_q != ZERO_C);
        end else begin
            m_tvalid_s = (pkt_cnt_q != ZERO_C);
        end
    end

    // Next-state logic for pointers, occupancy, packet count, FSM and registered flags.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        state_d   = state_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        count_d = count_q + {{AW{1'b0}}, wr_acc_s} - {{AW{1'b0}}, rd_acc_s};

        if (wr_last_s && !rd_last_s) begin
            pkt_cnt_d = pkt_cnt_q + ONE_C;
        end else if (!wr_last_s && rd_last_s) begin
            pkt_cnt_d = pkt_cnt_q - ONE_C;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end

        // A full FIFO with no complete packet can never drain in store mode.
        case (state_q)
            ST_STORE: begin
                if ((count_q == DEPTH_C) && (pkt_cnt_q == ZERO_C)) begin
                    state_d = ST_CUT;
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_CUT: begin
                if (rd_last_s) begin
                    state_d = ST_STORE;
                end else begin
                    state_d = ST_CUT;
                end
            end
            default: state_d = ST_STORE;
        endcase

        s_tready_d = (count_d != DEPTH_C);
        empty_d    = (count_d == ZERO_C);
        full_d     = (count_d == DEPTH_C);
        afull_d    = (count_d >= AF_C);
        aempty_d   = (count_d <= AE_C);
    end

    // Control and status registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {PW{1'b0}};
            pkt_cnt_q  <= {PW{1'b0}};
            state_q    <= ST_STORE;
            s_tready_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pkt_cnt_q  <= pkt_cnt_d;
            state_q    <= state_d;
            s_tready_q <= s_tready_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge aclk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

endmodule
